// File: rtl/sevenseg_scan_driver_if.sv
// Bus between the datapath and the seven-segment scan driver.
// The master supplies digit data and controls; the slave returns the pin-level drive.
interface sevenseg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                lz_blank;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, dp, load, lz_blank,
    input  seg, an, frame_done
  );

  modport slave (
    input  value, dp, load, lz_blank,
    output seg, an, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a blanking gap between
// digits, frame-aligned double buffering and optional leading-zero suppression.
module sevenseg_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sevenseg_scan_driver_if.slave  bus
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  // With no blanking gap the driver lives permanently in SCAN.
  localparam state_t ST_START = (BLANK_CYC == 0) ? ST_SCAN : ST_BLANK;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] active_val_q, active_val_d;
  logic [DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fd_q, fd_d;

  logic [3:0]          nib_s;
  logic                dp_s;
  logic                upper_zero_s;

  // Next-state, buffering and output decode; outputs are computed from next state
  // so the pins move on the same edge as the state and index.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_ONE;
    idx_d        = idx_q;
    fd_d         = 1'b0;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    nib_s        = 4'h0;
    dp_s         = 1'b0;
    upper_zero_s = 1'b1;
    seg_d        = 8'hFF;
    an_d         = '1;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          state_d = ST_START;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            fd_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d = ST_START;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (bus.load) begin
      shadow_val_d = bus.value;
      shadow_dp_d  = bus.dp;
    end else begin
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
    end

    // Taking the already-updated shadow gives the boundary-load bypass for free.
    if (fd_d) begin
      active_val_d = shadow_val_d;
      active_dp_d  = shadow_dp_d;
    end else begin
      active_val_d = active_val_q;
      active_dp_d  = active_dp_q;
    end

    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) == idx_d) begin
        nib_s = active_val_d[4*j +: 4];
        dp_s  = active_dp_d[j];
      end else begin
        nib_s = nib_s;
        dp_s  = dp_s;
      end
      if ((IW'(j) >= idx_d) && (active_val_d[4*j +: 4] != 4'h0)) begin
        upper_zero_s = 1'b0;
      end else begin
        upper_zero_s = upper_zero_s;
      end
      an_d[j] = ~((state_d == ST_SCAN) && (IW'(j) == idx_d));
    end

    if (state_d == ST_SCAN) begin
      if (bus.lz_blank && upper_zero_s && (idx_d != '0)) begin
        seg_d = {~dp_s, 7'h7F};
      end else begin
        seg_d = {~dp_s, hex_to_seg(nib_s)};
      end
    end else begin
      seg_d = 8'hFF;
    end
  end

  // State, buffers and registered pin drive.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_START;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fd_q         <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: a frame-arithmetic model checked every cycle,
// directed literal checks, then randomized loads and lz_blank toggling.
module tb_sevenseg_scan_driver;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.DIGITS(4)) bus0 ();
  sevenseg_scan_driver_if #(.DIGITS(1)) bus1 ();

  sevenseg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(2)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  sevenseg_scan_driver #(.DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(0)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int errors = 0;
  int checks = 0;

  // Model state: cycles since the last reset edge, shadow and displayed data.
  bit         mvalid = 1'b0;
  int         t = 0;
  logic [15:0] sh_v, ac_v;
  logic [3:0]  sh_d, ac_d;
  logic        lz_m;
  logic [3:0]  sh1_v, ac1_v;
  logic        sh1_d, ac1_d;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0d)", nm, act, exp, t);
    end
  endtask

  // Model update at each rising edge from the inputs the DUT samples there.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        mvalid = 1'b1;
        t = 0;
        sh_v = 16'h0; ac_v = 16'h0; sh_d = 4'h0; ac_d = 4'h0;
        sh1_v = 4'h0; ac1_v = 4'h0; sh1_d = 1'b0; ac1_d = 1'b0;
      end else if (mvalid) begin
        t++;
        if (bus0.load) begin sh_v = bus0.value; sh_d = bus0.dp; end
        if (t % 24 == 0) begin ac_v = sh_v; ac_d = sh_d; end
        if (bus1.load) begin sh1_v = bus1.value; sh1_d = bus1.dp[0]; end
        if (t % 4 == 0) begin ac1_v = sh1_v; ac1_d = sh1_d; end
      end
      lz_m = bus0.lz_blank;
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  initial begin
    int pos, dig;
    bit lit, blank;
    logic [7:0] e_seg, e_seg1;
    logic [3:0] e_an;
    logic e_fd, e_an1, e_fd1;
    forever begin
      @(negedge clk);
      if (mvalid) begin
        if (t == 0) begin
          e_seg = 8'hFF; e_an = 4'hF; e_fd = 1'b0;
          e_seg1 = 8'hFF; e_an1 = 1'b1; e_fd1 = 1'b0;
        end else begin
          pos = t % 24;
          dig = pos / 6;
          lit = (pos % 6) >= 2;
          blank = lz_m && (dig != 0) && ((ac_v >> (4 * dig)) == 16'h0);
          e_an = lit ? ~(4'b0001 << dig) : 4'hF;
          e_seg = lit ? {~ac_d[dig], blank ? 7'h7F : segtab[ac_v[4*dig +: 4]]} : 8'hFF;
          e_fd = (pos == 0);
          e_seg1 = {~ac1_d, segtab[ac1_v]};
          e_an1 = 1'b0;
          e_fd1 = (t % 4 == 0);
        end
        chk("seg0", {8'h00, bus0.seg}, {8'h00, e_seg});
        chk("an0", {12'h000, bus0.an}, {12'h000, e_an});
        chk("frame_done0", {15'h0, bus0.frame_done}, {15'h0, e_fd});
        chk("seg1", {8'h00, bus1.seg}, {8'h00, e_seg1});
        chk("an1", {15'h0, bus1.an}, {15'h0, e_an1});
        chk("frame_done1", {15'h0, bus1.frame_done}, {15'h0, e_fd1});
      end
    end
  end

  task automatic wait_t(input int target);
    int n = 0;
    while (!(mvalid && reset_n && t == target) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      errors++;
      checks++;
      $display("FAIL wait_t: timed out, t=%0d want %0d", t, target);
    end
  endtask

  task automatic load0(input logic [15:0] v, input logic [3:0] d);
    bus0.value = v; bus0.dp = d; bus0.load = 1'b1;
    @(negedge clk);
    bus0.load = 1'b0;
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus0.value = 16'h0; bus0.dp = 4'h0; bus0.load = 1'b0; bus0.lz_blank = 1'b0;
    bus1.value = 4'h0; bus1.dp = 1'b0; bus1.load = 1'b0; bus1.lz_blank = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset release, no load: blank/scan pattern and frame cadence.
    chk("lit_an_t0", {12'h0, bus0.an}, 16'h000F);
    wait_t(1);  chk("lit_an_t1", {12'h0, bus0.an}, 16'h000F);
                chk("lit_an1_t1", {15'h0, bus1.an}, 16'h0000);
    wait_t(2);  chk("lit_an_t2", {12'h0, bus0.an}, 16'h000E);
    wait_t(3);  chk("lit_seg_t3", {8'h0, bus0.seg}, 16'h00C0);
    wait_t(4);  chk("lit_fd1_t4", {15'h0, bus1.frame_done}, 16'h0001);
    wait_t(5);  chk("lit_an_t5", {12'h0, bus0.an}, 16'h000E);
    wait_t(6);  chk("lit_an_t6", {12'h0, bus0.an}, 16'h000F);
    wait_t(8);  chk("lit_an_t8", {12'h0, bus0.an}, 16'h000D);
    wait_t(20); chk("lit_an_t20", {12'h0, bus0.an}, 16'h0007);
    wait_t(23); chk("lit_fd_t23", {15'h0, bus0.frame_done}, 16'h0000);
    wait_t(24); chk("lit_fd_t24", {15'h0, bus0.frame_done}, 16'h0001);

    // Load 9B0D mid-frame; old data persists until the boundary.
    wait_t(30); load0(16'h9B0D, 4'b0100);
    wait_t(33); chk("old_dig1", {8'h0, bus0.seg}, 16'h00C0);
    wait_t(51); chk("dig0_D", {8'h0, bus0.seg}, 16'h00A1);
    wait_t(57); chk("dig1_0", {8'h0, bus0.seg}, 16'h00C0);
    wait_t(63); chk("dig2_b_dp", {8'h0, bus0.seg}, 16'h0003);
    wait_t(69); chk("dig3_9", {8'h0, bus0.seg}, 16'h0090);

    // Two loads in one frame, then a load on the boundary edge.
    wait_t(74); load0(16'h1111, 4'h0);
    wait_t(76); load0(16'h2222, 4'h0);
    wait_t(99); chk("last_load_wins", {8'h0, bus0.seg}, 16'h00A4);
    wait_t(119); load0(16'h3333, 4'h0);
    chk("boundary_fd", {15'h0, bus0.frame_done}, 16'h0001);
    wait_t(123); chk("boundary_bypass", {8'h0, bus0.seg}, 16'h00B0);

    // Leading-zero suppression.
    wait_t(125); bus0.lz_blank = 1'b1; load0(16'h0050, 4'h0);
    wait_t(147); chk("lz_dig0", {8'h0, bus0.seg}, 16'h00C0);
    wait_t(153); chk("lz_dig1", {8'h0, bus0.seg}, 16'h0092);
    wait_t(159); chk("lz_dig2", {8'h0, bus0.seg}, 16'h00FF);
                 chk("lz_dig2_an", {12'h0, bus0.an}, 16'h000B);
    wait_t(165); chk("lz_dig3", {8'h0, bus0.seg}, 16'h00FF);
                 chk("lz_dig3_an", {12'h0, bus0.an}, 16'h0007);
    wait_t(170); load0(16'h0000, 4'h0);
    wait_t(195); chk("lz0_dig0", {8'h0, bus0.seg}, 16'h00C0);
    wait_t(201); chk("lz0_dig1", {8'h0, bus0.seg}, 16'h00FF);

    // One-cycle reset during digit 2 scan.
    wait_t(205); bus0.lz_blank = 1'b0; load0(16'h9B0D, 4'b0100);
    wait_t(231); reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_seg", {8'h0, bus0.seg}, 16'h00FF);
    chk("rst_an", {12'h0, bus0.an}, 16'h000F);
    chk("rst_fd", {15'h0, bus0.frame_done}, 16'h0000);
    wait_t(3);  chk("rst_active_clr", {8'h0, bus0.seg}, 16'h00C0);
    wait_t(39); chk("rst_shadow_clr", {8'h0, bus0.seg}, 16'h00C0);

    // Randomized loads and lz_blank toggling.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus0.load = ($urandom_range(0, 9) == 0);
      bus0.value = rnd_val();
      bus0.dp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) bus0.lz_blank = ~bus0.lz_blank;
      bus1.load = ($urandom_range(0, 5) == 0);
      bus1.value = 4'($urandom_range(0, 15));
      bus1.dp = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus0.load = 1'b0; bus1.load = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
